// File: rtl/alu_pkg.sv
// Shared types for the ALU issuer: operand width, opcodes, FSM states and command layout.
package alu_pkg;
  localparam int W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  typedef struct packed {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/alu_issuer.sv
// Queues add/sub commands, drives the ALU one op at a time, returns its registered
// result and flags any disagreement with the built-in golden model.
module alu_issuer #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         alu_instruction,
  output logic [W-1:0] alu_inputA,
  output logic [W-1:0] alu_inputB,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_mismatch,
  output logic [7:0]   err_count
);
  import alu_pkg::*;

  localparam int CW = 1 + 2*W;

  state_e       state_q, state_d;
  logic         instr_q, instr_d;
  logic [W-1:0] in_a_q, in_a_d;
  logic [W-1:0] in_b_q, in_b_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         mism_q, mism_d;
  logic [7:0]   err_q, err_d;

  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [CW-1:0] fifo_head;
  logic          head_op;
  logic [W-1:0]  head_a, head_b, golden;

  assign cmd_ready = !fifo_full && !reset;
  assign fifo_push = cmd_valid && cmd_ready;

  alu_cmd_fifo #(.DEPTH(DEPTH), .DW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op = fifo_head[2*W];
  assign head_a  = fifo_head[2*W-1:W];
  assign head_b  = fifo_head[W-1:0];

  // The alu_* registers still hold the in-flight command during CAPTURE.
  assign golden = (instr_q == OP_SUB) ? (in_a_q - in_b_q) : (in_a_q + in_b_q);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    in_a_d      = in_a_q;
    in_b_d      = in_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    mism_d      = mism_q;
    err_d       = err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          instr_d  = head_op;
          in_a_d   = head_a;
          in_b_d   = head_b;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_result;
        mism_d      = (alu_result != golden);
        if ((alu_result != golden) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            instr_d  = head_op;
            in_a_d   = head_a;
            in_b_d   = head_b;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      instr_q     <= 1'b0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      mism_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      in_a_q      <= in_a_d;
      in_b_q      <= in_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mism_q      <= mism_d;
      err_q       <= err_d;
    end
  end

  assign alu_instruction = instr_q;
  assign alu_inputA      = in_a_q;
  assign alu_inputB      = in_b_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_mismatch    = mism_q;
  assign err_count       = err_q;
endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer with a behavioural registered ALU attached.
module tb_alu_issuer;
  import alu_pkg::*;

  logic       clk, reset;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic       alu_instruction;
  logic [3:0] alu_inputA, alu_inputB, alu_result;
  logic       rsp_valid, rsp_ready, rsp_mismatch;
  logic [3:0] rsp_data;
  logic [7:0] err_count;

  logic       alu_rst_n, force_zero;
  logic [3:0] alu_q;

  typedef struct {
    logic [3:0] d;
    logic       m;
  } exp_t;

  exp_t exp_q[$];
  int   hs_q[$];
  int   checks, errors, cyc;

  alu_issuer #(.W(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_instruction(alu_instruction), .alu_inputA(alu_inputA), .alu_inputB(alu_inputB),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_mismatch(rsp_mismatch), .err_count(err_count)
  );

  // Registered ALU with async active-low reset; force_zero models a broken ALU.
  assign alu_rst_n  = ~reset;
  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) alu_q <= 4'd0;
    else            alu_q <= alu_instruction ? (alu_inputA - alu_inputB) : (alu_inputA + alu_inputB);
  end
  assign alu_result = force_zero ? 4'd0 : alu_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every cycle a response is shown it must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_rsp", 1, 0);
        end else begin
          chk("rsp_data", int'(rsp_data), int'(exp_q[0].d));
          chk("rsp_mismatch", int'(rsp_mismatch), int'(exp_q[0].m));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            hs_q.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic send(input logic op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ed, input logic em);
    bit got;
    exp_t e;
    got = 0;
    e.d = ed;
    e.m = em;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1;
        break;
      end
    end
    if (got) exp_q.push_back(e);
    else     chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", int'(exp_q.size() != 0), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  cmd_t       vec[6];
  logic [3:0] vres[6];

  initial begin
    int n, idx;
    bit acc;
    exp_t e;
    checks = 0; errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b0; force_zero = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 0);
    chk("reset_alu_a", int'(alu_inputA), 0);
    chk("reset_err", int'(err_count), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_cmd_ready", int'(cmd_ready), 1);

    // Basic add with latency measurement
    send(OP_ADD, 4'd3, 4'd5, 4'd8, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 3);
    rsp_ready = 1'b1;
    drain();
    chk("err_after_add", int'(err_count), 0);

    // Wrap cases
    send(OP_SUB, 4'd2, 4'd5, 4'd13, 1'b0);
    send(OP_ADD, 4'd15, 4'd1, 4'd0, 1'b0);
    drain();

    // Backpressure: fill in-flight slot plus FIFO
    vec[0] = '{1'b0, 4'd1, 4'd2}; vres[0] = 4'd3;
    vec[1] = '{1'b1, 4'd9, 4'd4}; vres[1] = 4'd5;
    vec[2] = '{1'b0, 4'd8, 4'd8}; vres[2] = 4'd0;
    vec[3] = '{1'b1, 4'd0, 4'd1}; vres[3] = 4'd15;
    vec[4] = '{1'b0, 4'd6, 4'd7}; vres[4] = 4'd13;
    vec[5] = '{1'b0, 4'd1, 4'd1}; vres[5] = 4'd2;
    rsp_ready = 1'b0;
    idx = 0;
    cmd_valid = 1'b1;
    cmd_op = vec[0].op; cmd_a = vec[0].a; cmd_b = vec[0].b;
    for (int i = 0; i < 12; i++) begin
      acc = 0;
      @(negedge clk);
      if (cmd_ready && idx < 6) begin
        e.d = vres[idx];
        e.m = 1'b0;
        exp_q.push_back(e);
        acc = 1;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx < 6) begin
        cmd_op = vec[idx].op; cmd_a = vec[idx].a; cmd_b = vec[idx].b;
      end
    end
    cmd_valid = 1'b0;
    chk("accepted_when_blocked", idx, 5);
    chk("full_cmd_ready", int'(cmd_ready), 0);
    hs_q.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("cmd_ready_after_pop", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    drain();
    chk("resp_count", hs_q.size(), 5);
    for (int i = 1; i < hs_q.size(); i++) chk("throughput_gap", hs_q[i] - hs_q[i-1], 3);

    // Mismatch injection and saturation
    force_zero = 1'b1;
    send(OP_ADD, 4'd7, 4'd7, 4'd0, 1'b1);
    drain();
    chk("err_one", int'(err_count), 1);
    for (int i = 0; i < 300; i++) send(OP_ADD, 4'd7, 4'd7, 4'd0, 1'b1);
    drain();
    chk("err_saturated", int'(err_count), 255);
    force_zero = 1'b0;

    // Reset during CAPTURE of the first of three queued commands
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_a = 4'd1; cmd_b = 4'd1;
    @(posedge clk);
    #1;
    cmd_op = 1'b1; cmd_a = 4'd5; cmd_b = 4'd2;
    @(posedge clk);
    #1;
    cmd_op = 1'b0; cmd_a = 4'd3; cmd_b = 4'd3;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midop_rsp_valid", int'(rsp_valid), 0);
    chk("midop_alu_instr", int'(alu_instruction), 0);
    chk("midop_alu_a", int'(alu_inputA), 0);
    chk("midop_alu_b", int'(alu_inputB), 0);
    chk("midop_err", int'(err_count), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midop_cmd_ready", int'(cmd_ready), 1);
    repeat (15) @(posedge clk);
    #1;
    send(OP_ADD, 4'd4, 4'd4, 4'd8, 1'b0);
    drain();
    chk("err_after_reset_op", int'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issuer.md
# alu_issuer

Command-side initiator for the 4-bit add/subtract ALU. It accepts operation commands over a valid/ready interface and queues them in a small FIFO. It drives the ALU's `instruction`/`inputA`/`inputB` inputs one operation at a time, captures the ALU's registered result one cycle later, and returns it on a valid/ready response channel. It also compares each result against an internal golden model and flags mismatches, so it doubles as the ALU's self-checking driver in the verification lab.

## Interface
Parameters:
- `W`, 4: operand and result width; must match the ALU.
- `DEPTH`, 4: command FIFO depth; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  `!fifo_full`; 0 while `reset`=1.
- `cmd_op`  in  1  0 = add, 1 = subtract.
- `cmd_a`, `cmd_b`  in  W  operands.
- `alu_instruction`  out  1  to ALU `instruction`; registered.
- `alu_inputA`, `alu_inputB`  out  W  to ALU operands; registered.
- `alu_result`  in  W  from ALU `alu_out`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_data`  out  W  captured ALU result.
- `rsp_mismatch`  out  1  `rsp_data` differs from the golden result.
- `err_count`  out  8  saturating mismatch count.

## Operation
- Push: when `cmd_valid && cmd_ready`, write {op,a,b} into the FIFO. There is no bypass; a full FIFO blocks the push even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop, load the `alu_*` registers from the head entry, and go to ISSUE.
  - ISSUE: hold the `alu_*` drivers stable. The ALU latches at the end of this cycle. Go to CAPTURE.
  - CAPTURE: sample `alu_result` into `rsp_data`. Compute golden = (a + b) mod 2^W if op=0, (a − b) mod 2^W if op=1. Set `rsp_mismatch` = (`alu_result` != golden). Go to RESP.
  - RESP: hold `rsp_valid`=1 with data stable until `rsp_ready`. On the handshake: if the FIFO is non-empty, pop and go to ISSUE (same cycle); otherwise go to IDLE.
- `err_count` increments by 1 in CAPTURE when a mismatch occurs, saturating at 255. It is never cleared except by `reset`.
- `alu_*` outputs keep their last values in IDLE and RESP.
- Reset values: `alu_instruction`=0, `alu_inputA`=0, `alu_inputB`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_mismatch`=0, `err_count`=0, FIFO empty, FSM=IDLE.
- Reset asserted mid-operation aborts the in-flight operation and discards all queued commands. No response is produced for them.
- Arithmetic wraps modulo 2^W. There are no carry or borrow outputs.

## Timing
- Command accepted at edge t: FIFO written at t. IDLE pops at t+1. ISSUE occupies cycle t+1→t+2; the ALU latches at t+2. CAPTURE samples at t+3. `rsp_valid` is high from t+3 onward.
- Accept-to-`rsp_valid` latency with an empty pipeline: 3 cycles.
- Back-to-back throughput with `rsp_ready`=1: one operation per 3 cycles (RESP→ISSUE→CAPTURE).
- Capacity: `DEPTH` queued commands plus 1 in flight.
- `rsp_valid` never drops without `rsp_ready`. `rsp_data` and `rsp_mismatch` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- The ALU uses an asynchronous active-low reset. The top level drives it with `~reset`. While the ALU is in reset, its result reads 0 and may flag a mismatch.

## Structure
- `alu_pkg` holds: `W`; `OP_ADD`=1'b0 and `OP_SUB`=1'b1; the FSM state enum {IDLE, ISSUE, CAPTURE, RESP}; the command struct {op, a, b}.
- One sub-module, `alu_cmd_fifo`: synchronous FIFO with parameterised `DEPTH` and width 1+2W, providing full/empty flags and pointers one bit wider than log2(`DEPTH`).
- The golden model and FSM live in `alu_issuer`.

## Test plan
- Basic add: op=0, a=3, b=5, `rsp_ready`=1, real ALU attached → `rsp_valid` 3 cycles after accept, `rsp_data`=8, `rsp_mismatch`=0, `err_count`=0.
- Subtract wrap: op=1, a=2, b=5 → `rsp_data`=13 (0xD), no mismatch. Add wrap: op=0, a=15, b=1 → `rsp_data`=0, no mismatch.
- Backpressure and full: hold `rsp_ready`=0 and push commands continuously → 5 accepted (1 in flight + 4 queued), then `cmd_ready`=0. Release `rsp_ready` → 5 in-order responses, one every 3 cycles, and `cmd_ready` returns after the first pop.
- Mismatch injection: force `alu_result`=0 for op=0, a=7, b=7 → `rsp_data`=0, `rsp_mismatch`=1, `err_count`=1. Repeat 300 times → `err_count` holds at 255.
- Reset mid-op: queue 3 commands and assert `reset` during CAPTURE of the first → next cycle `rsp_valid`=0, `alu_*`=0, `cmd_ready`=1 after release, and no stale responses ever appear.
